full_adder_reg: RTL and testbench

Registered, width-parameterised ripple-carry adder built from 1-bit full-adder cells. It adds two operands and a carry-in and presents sum and carry-out from a register one clock after the inputs are sampled, with a valid flag travelling alongside. At the default WIDTH of 1 it is a clocked drop-in for the single-bit full adder used in the arithmetic datapath examples.

---
 rtl/full_adder_reg.sv | 65 ++++++
 tb/tb_full_adder_reg.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: WIDTH full-adder cells, one-cycle latency from sample to sum/count/out_vld.
// A new operation is accepted every cycle; there is no back-pressure.

module full_adder_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module full_adder_reg #(
   parameter int WIDTH = 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_1,
   input  logic [WIDTH-1:0] in_2,
   input  logic             cin,
   output logic             out_vld,
   output logic [WIDTH-1:0] sum,
   output logic             count
);
   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] r_sum;
   logic             r_count;
   logic             r_vld;

   assign w_carry[0] = cin;

   // The whole carry chain settles within one cycle; nothing is pipelined.
   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      full_adder_cell u_cell (
         .i_a (in_1[g]),
         .i_b (in_2[g]),
         .i_c (w_carry[g]),
         .o_s (w_sum[g]),
         .o_c (w_carry[g+1])
      );
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_sum   <= '0;
         r_count <= 1'b0;
         r_vld   <= 1'b0;
      end else begin
         r_vld <= in_vld;
         // Result registers only load on a qualified cycle, so junk on idle inputs never reaches them.
         if (in_vld) begin
            r_sum   <= w_sum;
            r_count <= w_carry[WIDTH];
         end
      end
   end

   assign sum     = r_sum;
   assign count   = r_count;
   assign out_vld = r_vld;
endmodule

// File: tb/tb_full_adder_reg.sv
// Bench for full_adder_reg at WIDTH=1 and WIDTH=8: truth table, corner vectors, random vs arithmetic model.
module tb_full_adder_reg;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vld1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
   logic       ov1, s1, co1;
   logic       vld8 = 1'b0, c8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       ov8, co8;
   logic [7:0] s8;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   full_adder_reg #(.WIDTH(1)) u_w1 (
      .sys_clk(clk), .sys_rst(rst), .in_vld(vld1), .in_1(a1), .in_2(b1), .cin(c1),
      .out_vld(ov1), .sum(s1), .count(co1)
   );

   full_adder_reg #(.WIDTH(8)) u_w8 (
      .sys_clk(clk), .sys_rst(rst), .in_vld(vld8), .in_1(a8), .in_2(b8), .cin(c8),
      .out_vld(ov8), .sum(s8), .count(co8)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_w1(input string nm, input logic [1:0] exp_cs, input logic exp_v);
      check({nm, " w1 {count,sum}"}, 32'({co1, s1}), 32'(exp_cs));
      check({nm, " w1 out_vld"}, 32'(ov1), 32'(exp_v));
   endtask

   task automatic check_w8(input string nm, input logic [8:0] exp_cs, input logic exp_v);
      check({nm, " w8 {count,sum}"}, 32'({co8, s8}), 32'(exp_cs));
      check({nm, " w8 out_vld"}, 32'(ov8), 32'(exp_v));
   endtask

   typedef struct {
      logic [2:0] abc;   // {in_1, in_2, cin}
      logic [1:0] cs;    // {count, sum}
   } vec1_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [7:0] s;
      logic       co;
   } vec8_t;

   vec1_t tt[8];
   vec8_t corner[2];

   initial begin
      logic [1:0] exp1;
      logic [8:0] exp8;
      logic       v8;

      tt[0] = '{3'b000, 2'b00};
      tt[1] = '{3'b001, 2'b01};
      tt[2] = '{3'b010, 2'b01};
      tt[3] = '{3'b011, 2'b10};
      tt[4] = '{3'b100, 2'b01};
      tt[5] = '{3'b101, 2'b10};
      tt[6] = '{3'b110, 2'b10};
      tt[7] = '{3'b111, 2'b11};
      corner[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
      corner[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

      // Reset held: outputs at zero even with a qualified input present.
      vld1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_w1("reset", 2'b00, 1'b0);
      check_w8("reset", 9'h000, 1'b0);
      vld1 = 1'b0;

      @(negedge clk);
      rst = 1'b0;

      // WIDTH=1 truth table, back to back.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         vld1 = 1'b1;
         {a1, b1, c1} = tt[i].abc;
         @(posedge clk);
         #1;
         check_w1($sformatf("truth %03b", tt[i].abc), tt[i].cs, 1'b1);
      end
      @(negedge clk);
      vld1 = 1'b0;

      // WIDTH=8 carry ripple and maximum operands.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vld8 = 1'b1;
         a8 = corner[i].a; b8 = corner[i].b; c8 = corner[i].c;
         @(posedge clk);
         #1;
         check_w8($sformatf("corner%0d", i), {corner[i].co, corner[i].s}, 1'b1);
      end
      exp8 = 9'h1FF;

      // Random: WIDTH=1 always qualified, WIDTH=8 with random gating and random idle inputs.
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         vld1 = 1'b1;
         a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
         exp1 = 2'(a1) + 2'(b1) + 2'(c1);
         v8 = ($urandom_range(0, 3) != 0);
         vld8 = v8;
         a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
         if (v8) exp8 = 9'(a8) + 9'(b8) + 9'(c8);
         @(posedge clk);
         #1;
         check_w1("random", exp1, 1'b1);
         check_w8("random", exp8, v8);
      end
      @(negedge clk);
      vld1 = 1'b0;

      // Hold and valid gating.
      vld8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
      @(posedge clk);
      #1;
      check_w8("hold load", 9'h046, 1'b1);
      @(negedge clk);
      vld8 = 1'b0; a8 = 8'hAA;
      @(posedge clk);
      #1;
      check_w8("hold idle", 9'h046, 1'b0);
      @(posedge clk);
      #1;
      check_w8("hold idle2", 9'h046, 1'b0);

      // Reset pulsed between edges with a result in flight: outputs drop before the next edge.
      @(negedge clk);
      vld8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
      #2 rst = 1'b1;
      #1;
      check_w8("async reset", 9'h000, 1'b0);
      @(posedge clk);
      #1;
      check_w8("reset in flight", 9'h000, 1'b0);

      // First edge after release samples normally.
      @(negedge clk);
      rst = 1'b0;
      a8 = 8'h80; b8 = 8'h80; c8 = 1'b1;
      @(posedge clk);
      #1;
      check_w8("post reset", 9'h101, 1'b1);
      @(negedge clk);
      vld8 = 1'b0;
      @(posedge clk);
      #1;
      check_w8("post reset idle", 9'h101, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
